cvxif_copro_mux: RTL
====================

# cvxif_copro_mux

Fans one CVXIF issue/result port of the core out to `NrCopro` coprocessors. It sits between `cva6` and the coprocessor instances, replacing the single hard-wired example coprocessor. It broadcasts each offloaded instruction to all coprocessors and records which one accepted it. It then merges their result streams through a registered round-robin arbiter, checking each result's ID against the recorded owner.

## Interface
Parameters:
- `NrCopro`, 2, number of coprocessors (≥1)
- `IdWidth`, 3, instruction ID width; owner table has 2**IdWidth entries
- `MaxOutstanding`, 4, accepted-but-unretired instruction limit (≤2**IdWidth)
- `XLEN`, riscv::XLEN, result data width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i`  in  1  clock
  - `rst_i`  in  1  synchronous active-high reset
- Core-side issue:
  - `issue_valid_i`  in  1  core issue request, held stable until `issue_ready_o`
  - `issue_ready_o`  out  1  issue handshake complete
  - `issue_instr_i`  in  32  offloaded instruction
  - `issue_id_i`  in  IdWidth  instruction ID
  - `issue_accept_o`  out  1  some coprocessor accepted (valid with ready)
  - `issue_writeback_o`  out  1  owner will write rd (valid with ready)
- Coprocessor-side issue:
  - `cp_issue_valid_o`  out  NrCopro  per-coprocessor issue valid
  - `cp_issue_instr_o`  out  32  broadcast instruction
  - `cp_issue_id_o`  out  IdWidth  broadcast ID
  - `cp_issue_ready_i`, `cp_issue_accept_i`, `cp_issue_writeback_i`  in  NrCopro  per-coprocessor response
- Coprocessor-side result:
  - `cp_result_valid_i`  in  NrCopro  result request
  - `cp_result_ready_o`  out  NrCopro  result grant/handshake
  - `cp_result_id_i`  in  NrCopro*IdWidth  packed IDs
  - `cp_result_data_i`  in  NrCopro*XLEN  packed data
  - `cp_result_we_i`  in  NrCopro  write-enable
- Core-side result:
  - `result_valid_o`, `result_id_o`, `result_data_o`, `result_we_o`  out  1/IdWidth/XLEN/1  merged result
  - `result_ready_i`  in  1  core accepts result
- Control and error:
  - `flush_i`  in  1  discard all in-flight state
  - `err_o`  out  1  one-cycle protocol-error pulse

## Operation
- Issue broadcast: state `done_q[NrCopro]`, `acc_q`, `wb_q`.
  - `cp_issue_valid_o[i] = issue_valid_i & ~done_q[i] & ~full & ~flush_i`.
  - Handshake at coprocessor i = valid & ready; it sets `done_q[i]` and ORs in its accept/writeback.
- Completion: the cycle in which every coprocessor is either `done_q` or handshaking now.
  - `issue_ready_o = 1`; `issue_accept_o`/`issue_writeback_o` = accumulated plus current bits.
  - `done_q`, `acc_q` and `wb_q` clear.
- Owner table: `own_v[id]`, `own_idx[id]`.
  - On accepted completion: set `own_v[issue_id_i]` and record the lowest accepting index.
  - More than one acceptor → `err_o`.
  - Accepting an ID already valid → `err_o` and overwrite.
  - full = popcount(`own_v`) == MaxOutstanding; while full, no issue handshakes occur.
- Result arbitration: round-robin from `rr_q`.
  - Grant g goes to the first valid requester at or after `rr_q`, only when the output register is empty or `result_ready_i`=1.
  - `cp_result_ready_o[g]=1`; `rr_q ← (g+1) mod NrCopro`.
- Ownership check: if `own_v[id] && own_idx[id]==g`, load the output register and clear `own_v[id]`; otherwise drop the result (handshake still completes) and pulse `err_o`.
- Same-cycle retire and issue of the same ID: set wins, no error.
- `flush_i` (priority over everything except reset):
  - clears `own_v`, `done_q`, `acc_q`, `wb_q` and the output register;
  - forces `issue_ready_o`=0 and `cp_result_ready_o`=0 that cycle.

## Timing
- Reset: all registers clear and `rr_q`=0. While `rst_i`=1 every output is 0, including the combinational ready/valid outputs.
- Issue:
  - latency 0 cycles when all coprocessors are ready in the first cycle;
  - otherwise completes in the cycle the last coprocessor handshakes.
- Result: 1-cycle latency from coprocessor handshake to `result_valid_o`. Full throughput: load and unload can occur in the same cycle.
- `result_*_o` are held stable while `result_valid_o & ~result_ready_i`.
- Reset or flush mid-broadcast: partial handshakes are discarded and the core must re-issue.

## Structure
- `cvxif_pkg` holds:
  - the owner-entry typedef (`valid`, `idx[$clog2(NrCopro)]`);
  - the packed result-port slice helper constants.
- Sub-module `cvxif_result_rr_arb`: parametrised `NrCopro` round-robin arbiter (req, en → gnt one-hot, idx, pointer update).

## Test plan
- NrCopro=2, both ready, copro1 accepts ID 3 → `issue_ready_o`/`issue_accept_o`=1 in cycle 0; copro1 later returns ID 3 data 0xABCD → `result_valid_o` next cycle, `own_v[3]` clears.
- Copro0 ready at cycle 0, copro1 at cycle 2 → `cp_issue_valid_o[0]` drops after cycle 0; `issue_ready_o` only in cycle 2.
- Both coprocessors present results every cycle, `result_ready_i`=1 → grants alternate 0,1,0,1 with one result per cycle.
- Four accepted IDs outstanding (MaxOutstanding=4) → fifth issue stalls with `issue_ready_o`=0 until one retires.
- Copro0 returns an ID owned by copro1 → result dropped, `err_o` pulses for 1 cycle, table unchanged.
- `flush_i` with the output register full and a half-done broadcast → next cycle `result_valid_o`=0, table empty, new issue proceeds normally.

Source files
------------

// File: rtl/cvxif_pkg.sv
// rtl/cvxif_pkg.sv - shared types and slice helpers for the CVXIF coprocessor mux
package cvxif_pkg;

    // Widest coprocessor index an owner entry can hold (up to 16 coprocessors).
    localparam int unsigned OWN_IDX_W = 4;

    // Result data width used when the integrating core does not override it.
    localparam int unsigned DEFAULT_XLEN = 64;

    // One owner-table entry: which coprocessor holds an in-flight instruction ID.
    typedef struct packed {
        logic                 valid;
        logic [OWN_IDX_W-1:0] idx;
    } own_entry_t;

    // LSB position of port slice `port` within a packed bus of `width`-bit fields.
    function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/cvxif_result_rr_arb.sv
// rtl/cvxif_result_rr_arb.sv - round-robin arbiter for coprocessor result requests
module cvxif_result_rr_arb #(
    parameter int unsigned NrCopro = 2,
    parameter int unsigned IdxW    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrCopro-1:0] req_i,
    input  logic               en_i,
    output logic [NrCopro-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               valid_o
);

    logic [IdxW-1:0] r_rr;
    logic            w_found;
    logic [IdxW-1:0] w_idx;
    logic [IdxW-1:0] w_k;

    // Search requesters starting at the pointer and wrapping; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = '0;
        for (int off = 0; off < int'(NrCopro); off++) begin
            w_k = IdxW'((int'(r_rr) + off) % int'(NrCopro));
            if (!w_found && req_i[w_k]) begin
                w_found = 1'b1;
                w_idx   = w_k;
            end
        end
    end

    assign valid_o = en_i & w_found;
    assign idx_o   = w_idx;
    assign gnt_o   = valid_o ? (NrCopro'(1) << w_idx) : '0;

    // Advance the pointer just past the winner whenever a grant is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (valid_o) begin
            r_rr <= (w_idx == IdxW'(NrCopro - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cvxif_copro_mux.sv
// rtl/cvxif_copro_mux.sv - fans one CVXIF port out to NrCopro coprocessors
module cvxif_copro_mux
    import cvxif_pkg::*;
#(
    parameter int unsigned NrCopro        = 2,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned XLEN           = DEFAULT_XLEN
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [31:0]                issue_instr_i,
    input  logic [IdWidth-1:0]         issue_id_i,
    output logic                       issue_accept_o,
    output logic                       issue_writeback_o,
    output logic [NrCopro-1:0]         cp_issue_valid_o,
    output logic [31:0]                cp_issue_instr_o,
    output logic [IdWidth-1:0]         cp_issue_id_o,
    input  logic [NrCopro-1:0]         cp_issue_ready_i,
    input  logic [NrCopro-1:0]         cp_issue_accept_i,
    input  logic [NrCopro-1:0]         cp_issue_writeback_i,
    input  logic [NrCopro-1:0]         cp_result_valid_i,
    output logic [NrCopro-1:0]         cp_result_ready_o,
    input  logic [NrCopro*IdWidth-1:0] cp_result_id_i,
    input  logic [NrCopro*XLEN-1:0]    cp_result_data_i,
    input  logic [NrCopro-1:0]         cp_result_we_i,
    output logic                       result_valid_o,
    output logic [IdWidth-1:0]         result_id_o,
    output logic [XLEN-1:0]            result_data_o,
    output logic                       result_we_o,
    input  logic                       result_ready_i,
    input  logic                       flush_i,
    output logic                       err_o
);

    localparam int unsigned NrIds = 2**IdWidth;
    localparam int unsigned IdxW  = (NrCopro > 1) ? $clog2(NrCopro) : 1;
    localparam int unsigned CntW  = $clog2(NrIds + 1);

    // Issue broadcast progress: who has handshaken, who accepted, any writeback.
    logic [NrCopro-1:0] r_done;
    logic [NrCopro-1:0] r_acc;
    logic               r_wb;

    own_entry_t r_own [NrIds];

    logic               r_res_valid;
    logic [IdWidth-1:0] r_res_id;
    logic [XLEN-1:0]    r_res_data;
    logic               r_res_we;

    logic               w_live;
    logic [CntW-1:0]    w_own_cnt;
    logic               w_full;
    logic               w_issue_go;
    logic [NrCopro-1:0] w_cp_valid;
    logic [NrCopro-1:0] w_hs;
    logic               w_complete;
    logic [NrCopro-1:0] w_acc_all;
    logic               w_wb_all;
    logic               w_accepted;
    logic [IdxW-1:0]    w_acc_idx;
    logic               w_acc_seen;
    logic               w_multi;
    logic               w_issue_err;

    logic               w_arb_en;
    logic [NrCopro-1:0] w_gnt;
    logic [IdxW-1:0]    w_gidx;
    logic               w_gvalid;
    logic [IdWidth-1:0] w_ids  [NrCopro];
    logic [XLEN-1:0]    w_datas[NrCopro];
    logic [IdWidth-1:0] w_res_id;
    own_entry_t         w_res_own;
    logic               w_res_ok;
    logic               w_res_bad;

    assign w_live = ~rst_i & ~flush_i;

    // Count valid owner entries to decide whether the outstanding limit is reached.
    always_comb begin
        w_own_cnt = '0;
        for (int i = 0; i < int'(NrIds); i++) begin
            w_own_cnt = w_own_cnt + CntW'(r_own[i].valid);
        end
    end

    assign w_full     = (w_own_cnt == CntW'(MaxOutstanding));
    assign w_issue_go = issue_valid_i & ~w_full & w_live;
    assign w_cp_valid = {NrCopro{w_issue_go}} & ~r_done;
    assign w_hs       = w_cp_valid & cp_issue_ready_i;
    assign w_complete = w_issue_go & (&(r_done | w_hs));
    assign w_acc_all  = r_acc | (w_hs & cp_issue_accept_i);
    assign w_wb_all   = r_wb | (|(w_hs & cp_issue_writeback_i));
    assign w_accepted = w_complete & (|w_acc_all);

    // Pick the lowest accepting coprocessor and flag more than one acceptor.
    always_comb begin
        w_acc_idx  = '0;
        w_acc_seen = 1'b0;
        w_multi    = 1'b0;
        for (int i = 0; i < int'(NrCopro); i++) begin
            if (w_acc_all[i]) begin
                if (w_acc_seen) begin
                    w_multi = 1'b1;
                end else begin
                    w_acc_idx = IdxW'(i);
                end
                w_acc_seen = 1'b1;
            end
        end
    end

    // Accumulate broadcast handshakes until every coprocessor has answered.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || w_complete) begin
            r_done <= '0;
            r_acc  <= '0;
            r_wb   <= 1'b0;
        end else begin
            r_done <= r_done | w_hs;
            r_acc  <= w_acc_all;
            r_wb   <= w_wb_all;
        end
    end

    cvxif_result_rr_arb #(
        .NrCopro (NrCopro),
        .IdxW    (IdxW)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (cp_result_valid_i),
        .en_i    (w_arb_en),
        .gnt_o   (w_gnt),
        .idx_o   (w_gidx),
        .valid_o (w_gvalid)
    );

    for (genvar g = 0; g < int'(NrCopro); g++) begin : g_unpack
        assign w_ids[g]   = cp_result_id_i[slice_lsb(g, IdWidth) +: IdWidth];
        assign w_datas[g] = cp_result_data_i[slice_lsb(g, XLEN) +: XLEN];
    end

    assign w_arb_en  = w_live & (~r_res_valid | result_ready_i);
    assign w_res_id  = w_ids[w_gidx];
    assign w_res_own = r_own[w_res_id];
    assign w_res_ok  = w_gvalid & w_res_own.valid & (w_res_own.idx == OWN_IDX_W'(w_gidx));
    assign w_res_bad = w_gvalid & ~w_res_ok;

    // A retire of the same ID in this cycle frees the entry, so re-accepting it is legal.
    assign w_issue_err = w_accepted &
                         (w_multi | (r_own[issue_id_i].valid & ~(w_res_ok & (w_res_id == issue_id_i))));

    // Owner table: retire clears, accepted issue sets afterwards so a same-ID set wins.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < int'(NrIds); i++) begin
                r_own[i] <= '0;
            end
        end else begin
            if (w_res_ok) begin
                r_own[w_res_id].valid <= 1'b0;
            end
            if (w_accepted) begin
                r_own[issue_id_i].valid <= 1'b1;
                r_own[issue_id_i].idx   <= OWN_IDX_W'(w_acc_idx);
            end
        end
    end

    // Result output register: load on an owned grant, otherwise drain on core ready.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_we    <= 1'b0;
        end else if (w_res_ok) begin
            r_res_valid <= 1'b1;
            r_res_id    <= w_res_id;
            r_res_data  <= w_datas[w_gidx];
            r_res_we    <= cp_result_we_i[w_gidx];
        end else if (result_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    assign issue_ready_o     = w_complete;
    assign issue_accept_o    = w_accepted;
    assign issue_writeback_o = w_complete & w_wb_all;
    assign cp_issue_valid_o  = w_cp_valid;
    assign cp_issue_instr_o  = rst_i ? '0 : issue_instr_i;
    assign cp_issue_id_o     = rst_i ? '0 : issue_id_i;
    assign cp_result_ready_o = w_gnt;
    assign result_valid_o    = ~rst_i & r_res_valid;
    assign result_id_o       = rst_i ? '0 : r_res_id;
    assign result_data_o     = rst_i ? '0 : r_res_data;
    assign result_we_o       = ~rst_i & r_res_we;
    assign err_o             = w_issue_err | w_res_bad;

endmodule
